// File: rtl/multicycle_controller.sv
// Multicycle instruction-sequencing controller with accelerator-channel handshake.
// Outputs decode combinationally from the current state plus instruction fields.
module multicycle_controller #(
  parameter int unsigned NUM_ACC  = 2,
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opCode,
  input  logic [2:0]         funct3,
  input  logic               branch,
  input  logic [NUM_ACC-1:0] accDone,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               DMemWrite,
  output logic               regFileWrite,
  output logic               ALUOverride,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               regFileWriteSrc,
  output logic               accSel,
  output logic [NUM_ACC-1:0] accStart,
  output logic [NUM_ACC-1:0] accWrEna,
  output logic               accTimeout,
  output logic [2:0]         state
);

  localparam logic [6:0] OP_ALU_REG = 7'b0110011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_ACC_LI  = 7'b0101011;
  localparam logic [6:0] OP_ACC_RUN = 7'b0001011;

  localparam logic       SRCA_REG  = 1'b0;
  localparam logic       SRCA_PC   = 1'b1;
  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_C4   = 2'd2;

  localparam logic [WAIT_W:0] WAIT_LIM = (WAIT_W+1)'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WAIT   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  state_e            state_q, state_d, cur_s;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [WAIT_W:0]   cnt_nxt;
  logic              tmo_q, tmo_d;
  logic              abort_q, abort_d;
  logic              ch_valid, ch_done, acc_run_v, acc_li_v;
  logic [7:0]        done_pad;
  logic [7:0]        ch_onehot;

  // Channel selection: funct3 names the channel; out-of-range channels decode as NOP
  always_comb begin
    done_pad                = '0;
    done_pad[NUM_ACC-1:0]   = accDone;
    ch_valid                = (32'(funct3) < NUM_ACC);
    ch_done                 = done_pad[funct3];
    ch_onehot               = 8'b1 << funct3;
    acc_run_v               = (opCode == OP_ACC_RUN) && ch_valid;
    acc_li_v                = (opCode == OP_ACC_LI) && ch_valid;
    cnt_nxt                 = {1'b0, cnt_q} + (WAIT_W+1)'(1);
  end

  // State, wait counter, sticky timeout and aborted mark
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      abort_q <= abort_d;
    end
  end

  // Next-state and output decode; reset presents the FETCH decode
  always_comb begin
    state_d         = S_FETCH;
    cnt_d           = cnt_q;
    tmo_d           = tmo_q;
    abort_d         = abort_q;
    PCWrite         = 1'b0;
    IRWrite         = 1'b0;
    DMemWrite       = 1'b0;
    regFileWrite    = 1'b0;
    ALUOverride     = 1'b0;
    ALUSrcA         = SRCA_REG;
    ALUSrcB         = SRCB_REG;
    regFileWriteSrc = 1'b0;
    accSel          = 1'b0;
    accStart        = '0;
    accWrEna        = '0;
    cur_s           = rst ? S_FETCH : state_q;
    state           = cur_s;
    accTimeout      = tmo_q & ~rst;

    case (cur_s)
      S_FETCH: begin
        IRWrite = 1'b1;
        abort_d = 1'b0;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (acc_li_v)  accWrEna = ch_onehot[NUM_ACC-1:0];
        if (acc_run_v) accStart = ch_onehot[NUM_ACC-1:0];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (opCode == OP_ALU_REG || opCode == OP_BRANCH) begin
          ALUSrcA = SRCA_REG;
          ALUSrcB = SRCB_REG;
        end else if (opCode == OP_JAL || opCode == OP_JALR) begin
          ALUSrcA = SRCA_PC;
          ALUSrcB = SRCB_C4;
        end else begin
          ALUSrcA = SRCA_REG;
          ALUSrcB = SRCB_IMM;
        end
        if (acc_run_v) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WAIT: begin
        accSel = 1'b1;
        cnt_d  = WAIT_W'(cnt_nxt);
        if (ch_done) begin
          state_d = S_MEM;
        end else if (cnt_nxt >= WAIT_LIM) begin
          tmo_d   = 1'b1;
          abort_d = 1'b1;
          state_d = S_MEM;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_MEM: begin
        ALUOverride = 1'b1;
        DMemWrite   = (opCode == OP_STORE);
        accSel      = acc_run_v && !abort_q;
        if (opCode == OP_JALR) begin
          ALUSrcA = SRCA_REG;
          ALUSrcB = SRCB_IMM;
        end else if (opCode == OP_JAL) begin
          ALUSrcA = SRCA_PC;
          ALUSrcB = SRCB_IMM;
        end else if (opCode == OP_BRANCH) begin
          ALUSrcA = SRCA_PC;
          ALUSrcB = branch ? SRCB_IMM : SRCB_C4;
        end else begin
          ALUSrcA = SRCA_PC;
          ALUSrcB = SRCB_C4;
        end
        state_d = S_WB;
      end
      S_WB: begin
        PCWrite = 1'b1;
        if (opCode == OP_STORE || opCode == OP_BRANCH || opCode == OP_ACC_LI) begin
          regFileWrite = 1'b0;
        end else if (opCode == OP_ACC_RUN) begin
          regFileWrite = ch_valid && !abort_q;
        end else begin
          regFileWrite    = 1'b1;
          regFileWriteSrc = (opCode == OP_LOAD);
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: default instance plus a MAX_WAIT=4 instance.
module tb_multicycle_controller;

  localparam logic [6:0] ALU_REG = 7'b0110011;
  localparam logic [6:0] ALU_IMM = 7'b0010011;
  localparam logic [6:0] LOAD    = 7'b0000011;
  localparam logic [6:0] STORE   = 7'b0100011;
  localparam logic [6:0] BRANCH  = 7'b1100011;
  localparam logic [6:0] JAL     = 7'b1101111;
  localparam logic [6:0] JALR    = 7'b1100111;
  localparam logic [6:0] ACC_LI  = 7'b0101011;
  localparam logic [6:0] ACC_RUN = 7'b0001011;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opCode;
  logic [2:0] funct3;
  logic       branch;
  logic [1:0] accDone;

  logic       pc_d, ir_d, dm_d, rf_d, ov_d, a_d, src_d, sel_d, tmo_d;
  logic [1:0] b_d, st_d, wr_d;
  logic [2:0] state_d;
  logic       pc_t, ir_t, dm_t, rf_t, ov_t, a_t, src_t, sel_t, tmo_t;
  logic [1:0] b_t, st_t, wr_t;
  logic [2:0] state_t;

  logic [17:0] obs_d, obs_t;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opCode(opCode), .funct3(funct3), .branch(branch), .accDone(accDone),
    .PCWrite(pc_d), .IRWrite(ir_d), .DMemWrite(dm_d), .regFileWrite(rf_d), .ALUOverride(ov_d),
    .ALUSrcA(a_d), .ALUSrcB(b_d), .regFileWriteSrc(src_d), .accSel(sel_d), .accStart(st_d),
    .accWrEna(wr_d), .accTimeout(tmo_d), .state(state_d)
  );

  multicycle_controller #(.NUM_ACC(2), .MAX_WAIT(4), .WAIT_W(8)) dut_t (
    .clk(clk), .rst(rst), .opCode(opCode), .funct3(funct3), .branch(branch), .accDone(accDone),
    .PCWrite(pc_t), .IRWrite(ir_t), .DMemWrite(dm_t), .regFileWrite(rf_t), .ALUOverride(ov_t),
    .ALUSrcA(a_t), .ALUSrcB(b_t), .regFileWriteSrc(src_t), .accSel(sel_t), .accStart(st_t),
    .accWrEna(wr_t), .accTimeout(tmo_t), .state(state_t)
  );

  assign obs_d = {pc_d, ir_d, dm_d, rf_d, ov_d, a_d, b_d, src_d, sel_d, st_d, wr_d, tmo_d, state_d};
  assign obs_t = {pc_t, ir_t, dm_t, rf_t, ov_t, a_t, b_t, src_t, sel_t, st_t, wr_t, tmo_t, state_t};

  function automatic logic [17:0] mk(input logic [2:0] st, input logic pc, input logic ir,
                                     input logic dm, input logic rf, input logic ov, input logic a,
                                     input logic [1:0] b, input logic src, input logic sel,
                                     input logic [1:0] start, input logic [1:0] wr, input logic to);
    return {pc, ir, dm, rf, ov, a, b, src, sel, start, wr, to, st};
  endfunction

  // Compare one instance's outputs mid-cycle, then advance to the next falling edge
  task automatic tick(input string tag, input logic [17:0] e, input bit use_t = 1'b0);
    logic [17:0] o;
    #1;
    o = use_t ? obs_t : obs_d;
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag, input bit use_t = 1'b0);
    rst = 1'b1;
    tick(tag, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), use_t);
    rst = 1'b0;
  endtask

  // One non-waiting instruction through FETCH..WRITEBACK on the default instance
  task automatic run_plain(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic br, input logic ea, input logic [1:0] eb,
                           input logic ma, input logic [1:0] mb, input logic dm,
                           input logic rf, input logic src, input logic [1:0] dwr);
    opCode = op; funct3 = f3; branch = br;
    tick({tag, ".F"}, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick({tag, ".D"}, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, dwr, 0));
    tick({tag, ".E"}, mk(2, 0, 0, 0, 0, 0, ea, eb, 0, 0, 0, 0, 0));
    tick({tag, ".M"}, mk(4, 0, 0, dm, 0, 1, ma, mb, 0, 0, 0, 0, 0));
    tick({tag, ".W"}, mk(5, 1, 0, 0, rf, 0, 0, 0, src, 0, 0, 0, 0));
  endtask

  initial begin
    rst = 1'b1; opCode = ALU_REG; funct3 = 3'd0; branch = 1'b0; accDone = 2'b00;
    @(negedge clk);
    do_reset("reset_d");
    rst = 1'b1;
    do_reset("reset_t", 1'b1);

    run_plain("alu_reg",     ALU_REG, 3'd0, 1'b0, 0, 2'd0, 1, 2'd2, 0, 1, 0, 2'b00);
    run_plain("branch_tk",   BRANCH,  3'd0, 1'b1, 0, 2'd0, 1, 2'd1, 0, 0, 0, 2'b00);
    run_plain("branch_nt",   BRANCH,  3'd0, 1'b0, 0, 2'd0, 1, 2'd2, 0, 0, 0, 2'b00);
    run_plain("store",       STORE,   3'd0, 1'b0, 0, 2'd1, 1, 2'd2, 1, 0, 0, 2'b00);
    run_plain("load",        LOAD,    3'd0, 1'b0, 0, 2'd1, 1, 2'd2, 0, 1, 1, 2'b00);
    run_plain("alu_imm",     ALU_IMM, 3'd0, 1'b0, 0, 2'd1, 1, 2'd2, 0, 1, 0, 2'b00);
    run_plain("jal",         JAL,     3'd0, 1'b0, 1, 2'd2, 1, 2'd1, 0, 1, 0, 2'b00);
    run_plain("jalr",        JALR,    3'd0, 1'b0, 1, 2'd2, 0, 2'd1, 0, 1, 0, 2'b00);
    run_plain("acc_li_ch5",  ACC_LI,  3'd5, 1'b0, 0, 2'd1, 1, 2'd2, 0, 0, 0, 2'b00);
    run_plain("acc_li_ch0",  ACC_LI,  3'd0, 1'b0, 0, 2'd1, 1, 2'd2, 0, 0, 0, 2'b01);
    run_plain("acc_run_ch2", ACC_RUN, 3'd2, 1'b0, 0, 2'd1, 1, 2'd2, 0, 0, 0, 2'b00);

    // ACC_RUN ch1: other channel's done ignored, own done in the 5th WAIT cycle
    opCode = ACC_RUN; funct3 = 3'd1;
    tick("run1.F", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick("run1.D", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0));
    tick("run1.E", mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    accDone = 2'b01;
    for (int i = 0; i < 4; i++) tick("run1.WAIT", mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    accDone = 2'b10;
    tick("run1.WAIT5", mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    accDone = 2'b00;
    tick("run1.M", mk(4, 0, 0, 0, 0, 1, 1, 2, 0, 1, 0, 0, 0));
    tick("run1.W", mk(5, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    // Timeout on the MAX_WAIT=4 instance, then sticky flag
    do_reset("reset_t2", 1'b1);
    funct3 = 3'd0;
    tick("tmo.F", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    tick("tmo.D", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0), 1'b1);
    tick("tmo.E", mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1);
    for (int i = 0; i < 4; i++) tick("tmo.WAIT", mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    tick("tmo.M", mk(4, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 1), 1'b1);
    tick("tmo.W", mk(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
    tick("tmo.sticky", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);

    // Done arriving on the final allowed cycle wins over timeout
    do_reset("reset_t3", 1'b1);
    tick("prio.F", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    tick("prio.D", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0), 1'b1);
    tick("prio.E", mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1);
    for (int i = 0; i < 3; i++) tick("prio.WAIT", mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    accDone = 2'b01;
    tick("prio.WAIT4", mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    accDone = 2'b00;
    tick("prio.M", mk(4, 0, 0, 0, 0, 1, 1, 2, 0, 1, 0, 0, 0), 1'b1);
    tick("prio.W", mk(5, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);

    // Reset in the 3rd WAIT cycle returns to FETCH without a new start pulse
    do_reset("reset_d2");
    funct3 = 3'd1;
    tick("rw.F", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick("rw.D", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0));
    tick("rw.E", mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tick("rw.WAIT1", mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tick("rw.WAIT2", mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    rst = 1'b1;
    tick("rw.rst", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0; opCode = ALU_REG; funct3 = 3'd0;
    tick("rw.F2", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick("rw.D2", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
